// File: rtl/seq_detect_fsm.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_fsm
// Purpose  : Run-time configurable serial pattern detector with match counter
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_fsm #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             clr_count,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat,
    output logic             cfg_err,
    output logic [1:0]       state_o,
    output logic [LEN_W-1:0] progress
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HUNT  = 2'd1,
        S_MATCH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [LEN_W-1:0] c_len_max = LEN_W'(PAT_W);

    state_t             r_state, w_state_nx;
    logic [PAT_W-1:0]   r_pat, w_pat_nx;
    logic [LEN_W-1:0]   r_len, w_len_nx;
    logic               r_ovl, w_ovl_nx;
    logic [PAT_W-1:0]   r_sh, w_sh_nx;
    logic [LEN_W-1:0]   r_fill, w_fill_nx;
    logic               w_pulse_nx;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic               w_sat_nx;
    logic               w_err_nx;

    logic [PAT_W-1:0]   w_mask;
    logic [PAT_W-1:0]   w_sh_shift;
    logic [LEN_W:0]     w_fill_inc;
    logic               w_hit;
    logic               w_len_ok;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_sh_shift = {r_sh[PAT_W-2:0], bit_in};
    assign w_fill_inc = (LEN_W+1)'(r_fill) + (LEN_W+1)'(1);
    // Fill must reach the window length and the newest len bits must agree.
    assign w_hit      = (w_fill_inc >= (LEN_W+1)'(r_len)) &&
                        (((w_sh_shift ^ r_pat) & w_mask) == '0);
    assign w_len_ok   = (cfg_len != '0) && (cfg_len <= c_len_max);

    always_comb begin
        w_state_nx = r_state;
        w_pat_nx   = r_pat;
        w_len_nx   = r_len;
        w_ovl_nx   = r_ovl;
        w_sh_nx    = r_sh;
        w_fill_nx  = r_fill;
        w_pulse_nx = 1'b0;
        w_cnt_nx   = match_count;
        w_sat_nx   = count_sat;
        w_err_nx   = cfg_err;

        if (cfg_load) begin
            w_pat_nx   = cfg_pattern;
            w_len_nx   = cfg_len;
            w_ovl_nx   = cfg_overlap;
            w_sh_nx    = '0;
            w_fill_nx  = '0;
            w_cnt_nx   = '0;
            w_sat_nx   = 1'b0;
            w_err_nx   = !w_len_ok;
            w_state_nx = w_len_ok ? S_HUNT : S_IDLE;
        end else begin
            if (clr_count) begin
                w_cnt_nx = '0;
                w_sat_nx = 1'b0;
            end
            if (r_state != S_IDLE) begin
                w_state_nx = S_HUNT;
                if (bit_valid) begin
                    w_sh_nx   = w_sh_shift;
                    w_fill_nx = (w_fill_inc >= (LEN_W+1)'(r_len)) ? r_len
                                                                  : w_fill_inc[LEN_W-1:0];
                    if (w_hit) begin
                        w_state_nx = S_MATCH;
                        w_pulse_nx = 1'b1;
                        if (!r_ovl) begin
                            w_fill_nx = '0;
                        end
                        if (clr_count) begin
                            w_cnt_nx = CNT_W'(1);
                            w_sat_nx = 1'b0;
                        end else if (match_count != c_cnt_max) begin
                            w_cnt_nx = match_count + CNT_W'(1);
                            w_sat_nx = ((match_count + CNT_W'(1)) == c_cnt_max);
                        end else begin
                            w_sat_nx = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pat       <= '0;
            r_len       <= '0;
            r_ovl       <= 1'b0;
            r_sh        <= '0;
            r_fill      <= '0;
            match_pulse <= 1'b0;
            match_count <= '0;
            count_sat   <= 1'b0;
            cfg_err     <= 1'b0;
        end else if (ena) begin
            r_state     <= w_state_nx;
            r_pat       <= w_pat_nx;
            r_len       <= w_len_nx;
            r_ovl       <= w_ovl_nx;
            r_sh        <= w_sh_nx;
            r_fill      <= w_fill_nx;
            match_pulse <= w_pulse_nx;
            match_count <= w_cnt_nx;
            count_sat   <= w_sat_nx;
            cfg_err     <= w_err_nx;
        end
    end

    assign state_o  = r_state;
    assign progress = r_fill;

endmodule
`default_nettype wire

// File: doc/seq_detect_fsm.md
Name: seq_detect_fsm

Overview:
Parametrised serial pattern-detector FSM. It is the next generation of the fixed-pattern FSM in the current tile top-level. Pattern, pattern length and overlap mode are set at run time, bits are qualified by a valid strobe, and matches are counted. It sits behind the tile top-level: ui_in provides the bit and strobe controls, uio_in provides the pattern, and uo_out carries status and count.

Parameters:
PAT_W, 8, maximum pattern length in bits (2..16)
CNT_W, 8, match counter width (2..16)
LEN_W, $clog2(PAT_W)+1, width of cfg_len and progress (derived; do not override)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ena  in  1  global enable; low freezes all state
cfg_load  in  1  one-cycle strobe; latch cfg_pattern, cfg_len and cfg_overlap
cfg_pattern  in  PAT_W  pattern; bit [len-1] is received first, bit [0] last
cfg_len  in  LEN_W  pattern length; valid range 1..PAT_W
cfg_overlap  in  1  1 = overlapping matches allowed
bit_valid  in  1  bit_in is sampled on this edge
bit_in  in  1  serial data bit
clr_count  in  1  synchronous clear of match_count and count_sat
match_pulse  out  1  registered one-cycle pulse per match
match_count  out  CNT_W  saturating match counter
count_sat  out  1  match_count is at all-ones
cfg_err  out  1  sticky; last cfg_load had an illegal length
state_o  out  2  0=IDLE, 1=HUNT, 2=MATCH
progress  out  LEN_W  valid bits held toward the current window, capped at cfg_len

Behaviour:
- Reset (async, rst_n=0): all outputs and internal registers are 0; state is IDLE; stored length is 0; shift register and fill count are 0.
- ena=0: every register holds its value; cfg_load, bit_valid and clr_count are ignored.
- cfg_load=1 with ena=1:
  - Latch the configuration and clear the shift register, fill count, match_count and count_sat.
  - If cfg_len is in 1..PAT_W: cfg_err<=0, next state is HUNT.
  - Otherwise: cfg_err<=1, next state is IDLE.
  - cfg_load takes priority over bit_valid and clr_count in the same cycle; a bit offered that cycle is dropped.
- IDLE: bits are ignored and match_pulse stays 0. The only exit is a legal cfg_load.
- HUNT or MATCH, on bit_valid=1:
  - sh <= {sh[PAT_W-2:0], bit_in}.
  - fill <= min(fill+1, len).
  - A match occurs when fill+1 >= len and the low len bits of the new sh equal the low len bits of the pattern.
  - On a match: next state is MATCH, match_pulse<=1, match_count increments.
  - On a match with cfg_overlap=0, fill<=0, so the next match needs len fresh bits.
  - On no match: next state is HUNT, match_pulse<=0.
- MATCH with bit_valid=0: return to HUNT, match_pulse<=0. match_pulse is never high for two cycles unless two consecutive valid bits both match.
- bit_valid gaps: the match window is not broken. Only valid bits count.
- Timing: match_pulse and match_count update on the same edge that samples the final pattern bit. There is no extra latency.
- match_count saturation:
  - At all-ones the count holds and count_sat=1.
  - match_pulse still fires on further matches.
  - If clr_count and a match occur in the same cycle, match_count<=1 and count_sat<=0.
- progress reflects fill; it is cleared by cfg_load and by a non-overlap match.
- The len=1 case must work: every valid bit equal to pattern[0] is a match.

Test Plan:
- Reset, then cfg_load with pattern=4'b1011, len=4, overlap=1. Feed bits 1,0,1,1,0,1,1 on consecutive cycles -> match_pulse high after the 4th and 7th bits; match_count=2; state_o returns to 1 after each pulse.
- Same stream with overlap=0 -> a single pulse after bit 4; match_count=1; progress=3 at the end.
- Same stream with random bit_valid=0 gaps inserted -> same pulse count as the first test. Pulses land on the edges of the 4th and 7th valid bits.
- CNT_W=2, len=1, pattern=1, feed five 1s -> match_count goes 1,2,3,3,3; count_sat=1 from the 3rd match. Then clr_count alone -> match_count=0, count_sat=0.
- cfg_load with len=0, then len=PAT_W+1 -> cfg_err=1, state_o=0, no pulses on any stream. A later legal load -> cfg_err=0, state_o=1.
- Drop rst_n mid-stream after 3 of 4 pattern bits -> all outputs are 0 immediately, without waiting for clk. After release, no match occurs until a new cfg_load is followed by a full pattern.
